// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and latched-request record for the direct-mapped cache controller.
package cache_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LINES     = 64;
    localparam int unsigned BLK_WORDS = 4;
    localparam int unsigned TAG_W     = 24;
    localparam int unsigned INDEX_W   = 6;
    localparam int unsigned OFFSET_W  = 2;
    localparam int unsigned BLK_W     = BLK_WORDS * DATA_W;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteBack,
        StAllocate,
        StRefill
    } cache_state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cpu_req_t;

endpackage

// File: rtl/cache_decoder.sv
// Splits a word address into tag, line index and word-in-block offset.
module cache_decoder
    import cache_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [TAG_W-1:0]    tag_o,
    output logic [INDEX_W-1:0]  index_o,
    output logic [OFFSET_W-1:0] offset_o
);

    assign tag_o    = addr_i[ADDR_W-1 -: TAG_W];
    assign index_o  = addr_i[OFFSET_W +: INDEX_W];
    assign offset_o = addr_i[OFFSET_W-1:0];

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped write-back/write-allocate cache controller with a block-wide memory port.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module dm_cache_controller
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_rw,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [BLK_W-1:0]  mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [BLK_W-1:0]  mem_resp_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    cache_state_t state_q, state_d;
    cpu_req_t     req_q;

    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [BLK_W-1:0] data_arr [LINES];
    logic [LINES-1:0] valid_q, dirty_q;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;

    logic              hit, victim_dirty, write_hit, refill_done, accept;
    logic [BLK_W-1:0]  line_rd;
    logic [DATA_W-1:0] word_rd;

    cache_decoder u_decoder (
        .addr_i   (req_q.addr),
        .tag_o    (tag),
        .index_o  (index),
        .offset_o (offset)
    );

    assign line_rd      = data_arr[index];
    assign word_rd      = line_rd[{offset, 5'b00000} +: DATA_W];
    assign hit          = valid_q[index] && (tag_arr[index] == tag);
    assign victim_dirty = valid_q[index] && dirty_q[index];
    assign accept       = (state_q == StIdle) && cpu_req_valid;
    assign write_hit    = (state_q == StCompare) && hit && req_q.rw;
    assign refill_done  = (state_q == StRefill) && mem_resp_valid;

    always_comb begin
        state_d        = state_q;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        unique case (state_q)
            StIdle: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_d = StCompare;
            end
            StCompare: begin
                if (hit) begin
                    cpu_resp_valid = 1'b1;
                    cpu_resp_rdata = req_q.rw ? '0 : word_rd;
                    state_d        = StIdle;
                end else begin
                    state_d = victim_dirty ? StWriteBack : StAllocate;
                end
            end
            StWriteBack: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {tag_arr[index], index, 2'b00};
                mem_req_wdata = line_rd;
                if (mem_req_ready) state_d = StAllocate;
            end
            StAllocate: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag, index, 2'b00};
                if (mem_req_ready) state_d = StRefill;
            end
            StRefill: begin
                if (mem_resp_valid) state_d = StCompare;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) req_q <= '{rw: cpu_req_rw, addr: cpu_req_addr, wdata: cpu_req_wdata};
            if (write_hit) dirty_q[index] <= 1'b1;
            if (refill_done) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
        end
    end

    // Tag and data storage is deliberately left unreset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (write_hit) data_arr[index][{offset, 5'b00000} +: DATA_W] <= req_q.wdata;
            if (refill_done) begin
                data_arr[index] <= mem_resp_rdata;
                tag_arr[index]  <= tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Only the first COMPARE of a request counts; the post-refill pass is skipped.
    logic first_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            first_q <= 1'b1;
        end else if (state_q == StCompare) begin
            first_q <= 1'b0;
            if (first_q) begin
                if (hit) hit_count <= hit_count + 32'd1;
                else     miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_controller.sv
// Directed, table-driven bench for dm_cache_controller with hand-written memory-stall and reset sequences.
module tb_dm_cache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req_valid, cpu_req_rw;
    logic [31:0]  cpu_req_addr, cpu_req_wdata;
    logic         cpu_req_ready, cpu_resp_valid;
    logic [31:0]  cpu_resp_rdata;
    logic         mem_req_valid, mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_req_ready, mem_resp_valid;
    logic [127:0] mem_resp_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    dm_cache_controller dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] refill;
        logic         exp_wb;
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        logic         exp_fetch;
        logic [31:0]  fetch_addr;
        logic [31:0]  rdata;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stats(input string name);
`ifdef CACHE_STATS_EN
        chk({name, "_hits"}, 128'(hit_count), 128'(exp_hits));
        chk({name, "_miss"}, 128'(miss_count), 128'(exp_miss));
`else
        if (name.len() == 0) $display("stats disabled");
`endif
    endtask

    // Issues one request, plays memory (ready tied high) and checks traffic, data and latency.
    task automatic run_vec(input vec_t v, input string name);
        int           cyc = 1;
        bit           got_resp = 0, saw_wb = 0, saw_fetch = 0, fetch_pending = 0;
        logic [31:0]  wb_addr = '0, f_addr = '0, rdata = '0;
        logic [127:0] wb_data = '0;
        int           lat = 0;
        @(negedge clk);
        chk({name, "_ready"}, 128'(cpu_req_ready), 128'(1));
        cpu_req_valid = 1'b1;
        cpu_req_rw    = v.rw;
        cpu_req_addr  = v.addr;
        cpu_req_wdata = v.wdata;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        while (!got_resp && cyc <= 40) begin
            mem_resp_valid = 1'b0;
            if (fetch_pending) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = v.refill;
                fetch_pending  = 0;
            end
            if (cpu_resp_valid) begin
                got_resp = 1;
                rdata    = cpu_resp_rdata;
                lat      = cyc;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_rw) begin
                    saw_wb  = 1;
                    wb_addr = mem_req_addr;
                    wb_data = mem_req_wdata;
                end else begin
                    saw_fetch     = 1;
                    f_addr        = mem_req_addr;
                    fetch_pending = 1;
                end
            end
            if (!got_resp) begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_resp_valid = 1'b0;
        chk({name, "_resp"}, 128'(got_resp), 128'(1));
        chk({name, "_rdata"}, 128'(rdata), 128'(v.rdata));
        chk({name, "_lat"}, 128'(lat), 128'(v.lat));
        chk({name, "_wb"}, 128'(saw_wb), 128'(v.exp_wb));
        if (v.exp_wb) begin
            chk({name, "_wb_addr"}, 128'(wb_addr), 128'(v.wb_addr));
            chk({name, "_wb_data"}, wb_data, v.wb_data);
        end
        chk({name, "_fetch"}, 128'(saw_fetch), 128'(v.exp_fetch));
        if (v.exp_fetch) chk({name, "_fetch_addr"}, 128'(f_addr), 128'(v.fetch_addr));
        if (v.exp_fetch) exp_miss++;
        else             exp_hits++;
        check_stats(name);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 32'h0000_0106, 32'h0, 128'h44443333_22221111_00000000_AAAA0000,
                    1'b0, 32'h0, 128'h0, 1'b1, 32'h0000_0104, 32'h22221111, 4};
        vecs[1] = '{1'b0, 32'h0000_0105, 32'h0, 128'h0,
                    1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h00000000, 1};
        vecs[2] = '{1'b1, 32'h0000_0107, 32'hDEADBEEF, 128'h0,
                    1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h00000000, 1};
        vecs[3] = '{1'b0, 32'h0000_0204, 32'h0, 128'h55555555_66666666_77777777_88888888,
                    1'b1, 32'h0000_0104, 128'hDEADBEEF_22221111_00000000_AAAA0000,
                    1'b1, 32'h0000_0204, 32'h88888888, 5};
        vecs[4] = '{1'b0, 32'h0000_0207, 32'h0, 128'h0,
                    1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h55555555, 1};
        vecs[5] = '{1'b1, 32'h0000_030A, 32'h12345678, 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D,
                    1'b0, 32'h0, 128'h0, 1'b1, 32'h0000_0308, 32'h00000000, 4};
        vecs[6] = '{1'b0, 32'h0000_030A, 32'h0, 128'h0,
                    1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h12345678, 1};
        vecs[7] = '{1'b0, 32'h0000_0309, 32'h0, 128'h0,
                    1'b0, 32'h0, 128'h0, 1'b0, 32'h0, 32'h0C0C0C0C, 1};
        vecs[8] = '{1'b0, 32'h0000_0000, 32'h0, 128'h13131313_14141414_15151515_16161616,
                    1'b0, 32'h0, 128'h0, 1'b1, 32'h0000_0000, 32'h16161616, 4};
        vecs[9] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 128'h90000003_90000002_90000001_90000000,
                    1'b0, 32'h0, 128'h0, 1'b1, 32'hFFFF_FFFC, 32'h90000003, 4};

        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_ready", 128'(cpu_req_ready), 128'(1));
        chk("rst_resp_valid", 128'(cpu_resp_valid), 128'(0));
        chk("rst_rdata", 128'(cpu_resp_rdata), 128'(0));
        chk("rst_mem_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_mem_rw", 128'(mem_req_rw), 128'(0));
        chk("rst_mem_addr", 128'(mem_req_addr), 128'(0));
        chk("rst_mem_wdata", mem_req_wdata, 128'(0));
        check_stats("rst");

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Dirty victim at line 2 (tag 3); stall the write-back.
        @(negedge clk);
        chk("stall_ready", 128'(cpu_req_ready), 128'(1));
        mem_req_ready = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_0408;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        exp_miss++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), 128'(mem_req_valid), 128'(1));
            chk($sformatf("stall%0d_rw", i), 128'(mem_req_rw), 128'(1));
            chk($sformatf("stall%0d_addr", i), 128'(mem_req_addr), 128'h308);
            chk($sformatf("stall%0d_wdata", i), mem_req_wdata,
                128'h0A0A0A0A_12345678_0C0C0C0C_0D0D0D0D);
            chk($sformatf("stall%0d_resp", i), 128'(cpu_resp_valid), 128'(0));
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("alloc_valid", 128'(mem_req_valid), 128'(1));
        chk("alloc_rw", 128'(mem_req_rw), 128'(0));
        chk("alloc_addr", 128'(mem_req_addr), 128'h408);
        @(negedge clk);
        chk("refill_mem_valid", 128'(mem_req_valid), 128'(0));

        // Reset while waiting for refill data.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        chk("midrst_ready", 128'(cpu_req_ready), 128'(1));
        chk("midrst_mem_valid", 128'(mem_req_valid), 128'(0));
        chk("midrst_resp_valid", 128'(cpu_resp_valid), 128'(0));
        chk("midrst_rdata", 128'(cpu_resp_rdata), 128'(0));
        check_stats("midrst");

        mem_resp_valid = 1'b1;
        mem_resp_rdata = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("stray_ready", 128'(cpu_req_ready), 128'(1));
        chk("stray_resp", 128'(cpu_resp_valid), 128'(0));
        chk("stray_mem_valid", 128'(mem_req_valid), 128'(0));

        v = '{1'b0, 32'h0000_0204, 32'h0, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
              1'b0, 32'h0, 128'h0, 1'b1, 32'h0000_0204, 32'hA0A0A0A0, 4};
        run_vec(v, "post_rst");

        @(negedge clk);
        chk("final_resp_pulse", 128'(cpu_resp_valid), 128'(0));
        chk("final_ready", 128'(cpu_req_ready), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
